// File: rtl/async_hs_tx_if.sv
// Bundled-data transmit interface: upstream valid/ready word stream plus the
// 4-phase req/ack pair and bundled data toward the downstream C-element stage.
interface async_hs_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              req_out;
   logic [DATA_W-1:0] data_out;
   logic              ack_in;

   modport master (
      output in_valid, in_data, ack_in,
      input  in_ready, req_out, data_out
   );

   modport slave (
      input  in_valid, in_data, ack_in,
      output in_ready, req_out, data_out
   );
endinterface

// File: rtl/async_hs_tx.sv
// FIFO-buffered 4-phase bundled-data transmitter with a synchronized ack,
// one-cycle data setup margin and a sticky ack-timeout flag.
module async_hs_tx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   async_hs_tx_if.slave             bus,
   input  logic                     err_clr,
   output logic                     busy,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StSetup, StReqHi, StReqLo} state_e;

   state_e                   state_q, state_d;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]         level_q;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     req_q, req_d;
   logic [DATA_W-1:0]        data_q, data_d;
   logic                     push, pop, ack_s, in_ready, timeout_hit;

   assign ack_s    = sync_q[SYNC_STAGES-1];
   assign in_ready = rst_n & (level_q < LVL_W'(DEPTH));
   assign push     = bus.in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A high ack_s means the previous cycle (or pre-reset state) has
            // not returned to zero yet; never start a handshake on top of it.
            if (level_q != '0 && !ack_s) begin
               pop     = 1'b1;
               data_d  = mem[rd_ptr_q];
               state_d = StSetup;
            end
         end
         StSetup: begin
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = StReqHi;
         end
         StReqHi, StReqLo: begin
            if ((state_q == StReqHi) == ack_s) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = (state_q == StReqHi) ? StReqLo : StIdle;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d       = cnt_q + CNT_W'(1);
               timeout_hit = (cnt_q == CNT_MAX - CNT_W'(1));
            end
         end
         default: state_d = StIdle;
      endcase
      err_d = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   assign bus.in_ready = in_ready;
   assign bus.req_out  = req_q;
   assign bus.data_out = data_q;
   assign busy         = (state_q != StIdle) | (level_q != '0);
   assign timeout_err  = err_q;
   assign level        = level_q;

endmodule

// File: tb/tb_async_hs_tx.sv
// Directed bench for async_hs_tx: vector table for a single handshake plus
// sequences for timeout, burst, full FIFO, reset mid-handshake and random acks.
`timescale 1ns/1ps
module tb_async_hs_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       err_clr;
   logic       busy;
   logic       timeout_err;
   logic [2:0] level;

   async_hs_tx_if #(.DATA_W(8)) ifc ();

   async_hs_tx #(
      .DATA_W      (8),
      .DEPTH       (4),
      .SYNC_STAGES (2),
      .TIMEOUT     (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (ifc),
      .err_clr     (err_clr),
      .busy        (busy),
      .timeout_err (timeout_err),
      .level       (level)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ack responder controls (written only by the main sequence)
   bit   ack_auto = 1'b0;
   bit   ack_rand = 1'b0;
   int   ack_dly  = 3;
   logic ack_man  = 1'b0;
   int   ack_wait = 0;

   logic [7:0] rx[$];
   logic [7:0] sent[$];
   int         stab_viol = 0;
   logic       prev_req  = 1'b0;
   logic [7:0] prev_data = 8'h00;
   bit         saw_full  = 1'b0;

   typedef struct {
      logic       vld;
      logic [7:0] din;
      logic       ack;
      logic       rdy;
      logic [2:0] lvl;
      logic       req;
      logic [7:0] dout;
      logic       bsy;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = 8'h00;
      err_clr       = 1'b0;
      tick();
      tick();
      chk("ready_in_reset", ifc.in_ready, 1'b0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push_word(input logic [7:0] d, input int budget);
      int   n;
      logic rdy;
      n = 0;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      do begin
         rdy = ifc.in_ready;
         if (level == 3'd4) begin
            saw_full = 1'b1;
            chk("ready_at_full", ifc.in_ready, 1'b0);
         end
         tick();
         n++;
      end while (!rdy && n < budget);
      ifc.in_valid = 1'b0;
      chk("push_accept", rdy, 1'b1);
   endtask

   task automatic wait_req(input logic v, input int budget);
      int n;
      n = 0;
      while (ifc.req_out !== v && n < budget) begin
         tick();
         n++;
      end
      chk("wait_req", ifc.req_out, v);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      chk("wait_idle", busy, 1'b0);
   endtask

   // ack_in follows req_out after a programmable or random number of cycles
   initial begin
      ifc.ack_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!ack_auto) begin
            ifc.ack_in = ack_man;
            ack_wait   = 0;
         end else if (ifc.req_out !== ifc.ack_in) begin
            if (ack_wait == 0) begin
               ifc.ack_in = ifc.req_out;
               ack_wait   = ack_rand ? int'($urandom_range(20, 0)) : ack_dly;
            end else begin
               ack_wait--;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && prev_req && ifc.req_out && ifc.data_out !== prev_data)
         stab_viol <= stab_viol + 1;
      if (rst_n && ifc.req_out && !prev_req) rx.push_back(ifc.data_out);
      prev_req  <= rst_n & ifc.req_out;
      prev_data <= ifc.data_out;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int   bad;
      int   rises;
      logic [7:0] w;

      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b0};

      // reset state
      do_reset();
      chk("rst_level", level, 3'd0);
      chk("rst_req", ifc.req_out, 1'b0);
      chk("rst_data", ifc.data_out, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", timeout_err, 1'b0);
      chk("rst_ready", ifc.in_ready, 1'b1);

      // single word, cycle by cycle
      for (int i = 0; i < 9; i++) begin
         ifc.in_valid = tbl[i].vld;
         ifc.in_data  = tbl[i].din;
         ack_man      = tbl[i].ack;
         tick();
         chk($sformatf("v%0d_ready", i), ifc.in_ready, tbl[i].rdy);
         chk($sformatf("v%0d_level", i), level, tbl[i].lvl);
         chk($sformatf("v%0d_req", i), ifc.req_out, tbl[i].req);
         chk($sformatf("v%0d_data", i), ifc.data_out, tbl[i].dout);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      end
      chk("v_err", timeout_err, 1'b0);

      // ack stall and timeout
      do_reset();
      ack_man = 1'b0;
      push_word(8'h3C, 10);
      wait_req(1'b1, 10);
      for (int i = 1; i < 10; i++) begin
         tick();
         chk($sformatf("to_pre%0d", i), timeout_err, 1'b0);
      end
      tick();
      chk("to_set", timeout_err, 1'b1);
      chk("to_req_held", ifc.req_out, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_cleared", timeout_err, 1'b0);
      repeat (3) tick();
      chk("to_stay_clear", timeout_err, 1'b0);
      chk("to_req_still", ifc.req_out, 1'b1);
      ack_man = 1'b1;
      wait_req(1'b0, 10);
      ack_man = 1'b0;
      wait_idle(10);
      chk("to_data", ifc.data_out, 8'h3C);
      chk("to_err_end", timeout_err, 1'b0);

      // back-to-back burst with a 3-cycle ack delay
      do_reset();
      ack_auto = 1'b1;
      ack_rand = 1'b0;
      ack_dly  = 3;
      rx.delete();
      saw_full = 1'b0;
      for (int i = 1; i <= 6; i++) push_word(8'(i), 200);
      wait_idle(300);
      chk("burst_full_seen", saw_full, 1'b1);
      chk("burst_count", rx.size(), 6);
      for (int i = 0; i < 6 && i < rx.size(); i++)
         chk($sformatf("burst_w%0d", i), rx[i], 8'(i + 1));

      // held ack blocks IDLE; push/pop at DEPTH-1; push at DEPTH ignored
      do_reset();
      ack_auto = 1'b0;
      ack_man  = 1'b1;
      rx.delete();
      repeat (3) tick();
      push_word(8'h11, 5);
      push_word(8'h22, 5);
      push_word(8'h33, 5);
      repeat (4) tick();
      chk("hold_level", level, 3'd3);
      chk("hold_req", ifc.req_out, 1'b0);
      chk("hold_data", ifc.data_out, 8'h00);
      ack_man = 1'b0;
      tick();
      tick();
      chk("hold_level2", level, 3'd3);
      ifc.in_valid = 1'b1;
      ifc.in_data  = 8'h44;
      tick();
      chk("pp_level", level, 3'd3);
      chk("pp_data", ifc.data_out, 8'h11);
      ifc.in_data = 8'h55;
      tick();
      chk("full_level", level, 3'd4);
      chk("full_ready", ifc.in_ready, 1'b0);
      ifc.in_data = 8'h66;
      tick();
      ifc.in_valid = 1'b0;
      chk("ignored_level", level, 3'd4);
      chk("ignored_req", ifc.req_out, 1'b1);
      ack_auto = 1'b1;
      ack_dly  = 2;
      wait_idle(300);
      chk("pp_count", rx.size(), 5);
      for (int i = 0; i < 5 && i < rx.size(); i++) begin
         w = 8'h11 * 8'(i + 1);
         chk($sformatf("pp_w%0d", i), rx[i], w);
      end

      // reset while in REQ_HI with two words queued
      ack_auto = 1'b0;
      do_reset();
      ack_man = 1'b0;
      push_word(8'h81, 5);
      push_word(8'h82, 5);
      push_word(8'h83, 5);
      chk("mid_req", ifc.req_out, 1'b1);
      chk("mid_level", level, 3'd2);
      chk("mid_data", ifc.data_out, 8'h81);
      rst_n   = 1'b0;
      ack_man = 1'b1;
      tick();
      chk("mr_req", ifc.req_out, 1'b0);
      chk("mr_level", level, 3'd0);
      chk("mr_data", ifc.data_out, 8'h00);
      chk("mr_ready", ifc.in_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("mr_ready_rel", ifc.in_ready, 1'b1);
      repeat (3) tick();
      push_word(8'h99, 5);
      rises = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ifc.req_out) rises++;
      end
      chk("mr_no_req", rises, 0);
      chk("mr_level_held", level, 3'd1);
      ack_man = 1'b0;
      wait_req(1'b1, 20);
      chk("mr_data_new", ifc.data_out, 8'h99);
      ack_man = 1'b1;
      wait_req(1'b0, 20);
      ack_man = 1'b0;
      wait_idle(20);

      // random ack delays over 1000 words
      do_reset();
      rx.delete();
      sent.delete();
      stab_viol = 0;
      ack_auto  = 1'b1;
      ack_rand  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         w = 8'($urandom);
         if ($urandom_range(3, 0) == 0) tick();
         push_word(w, 200);
         sent.push_back(w);
      end
      wait_idle(2000);
      chk("rand_count", rx.size(), sent.size());
      bad = 0;
      for (int i = 0; i < sent.size() && i < rx.size(); i++)
         if (rx[i] !== sent[i]) bad++;
      chk("rand_order", bad, 0);
      chk("rand_stable", stab_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/async_hs_tx.md
ASYNC_HS_TX -- requirements
Module: async_hs_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of the bundled-data payload.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2: flop count of the ack_in synchronizer, at least 2.
REQ-004 Parameter TIMEOUT, default 255: cycles waited on a single ack edge before flagging an error, at least 1.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  upstream word offered.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 in_data  input  DATA_W  upstream word.
REQ-010 req_out  output  1  4-phase request to the downstream C-element stage; registered, glitch-free.
REQ-011 data_out  output  DATA_W  bundled data; registered; stable whenever req_out=1.
REQ-012 ack_in  input  1  asynchronous 4-phase acknowledge from the C-element output.
REQ-013 err_clr  input  1  clears timeout_err.
REQ-014 busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
REQ-015 timeout_err  output  1  sticky flag for an ack timeout.
REQ-016 level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Push rule: a word is pushed when in_valid and in_ready are both 1 at a rising edge.
REQ-018 in_ready rule: in_ready = (level < DEPTH), computed from registered level only.
- A pop in the same cycle does not raise in_ready.
- A push to a full FIFO is ignored.
REQ-019 FIFO behaviour: first-in first-out; pointers wrap modulo DEPTH; level changes by at most 1 per cycle; a simultaneous push and pop leaves level unchanged.
REQ-020 ack synchronization: ack_s is ack_in delayed through SYNC_STAGES flops; ack_in is used only through ack_s.
REQ-021 FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
REQ-022 IDLE: when level>0, pop the head into data_out and go to SETUP; otherwise stay in IDLE.
REQ-023 SETUP: hold for exactly one cycle (bundled-data setup margin), then set req_out=1 and go to REQ_HI.
REQ-024 REQ_HI: hold req_out=1 until ack_s=1, then clear req_out and go to REQ_LO.
REQ-025 REQ_LO: hold req_out=0 until ack_s=0, then go to IDLE.
REQ-026 data_out changes only on the IDLE->SETUP transition.
REQ-027 Latency: a word pushed at edge t into an empty FIFO with the FSM in IDLE appears on data_out after edge t+1, and req_out rises after edge t+2.
REQ-028 Throughput: back-to-back words need at least 1 cycle in IDLE between handshakes; no word is sent without a full 4-phase cycle.
REQ-029 Timeout counter:
- cleared on entry to REQ_HI or REQ_LO;
- incremented each cycle spent waiting in either state;
- on reaching TIMEOUT, timeout_err is set to 1 and the counter saturates;
- the FSM keeps waiting and never aborts a handshake.
REQ-030 err_clr=1 clears timeout_err at the next edge; a new timeout in the same cycle takes priority and sets it.
REQ-031 If ack_s is already 1 on entry to REQ_HI (a protocol violation), the FSM advances normally on the next edge.

Reset
REQ-032 While rst_n=0 at an edge, all of the following are cleared:
- FIFO emptied, level=0;
- FSM to IDLE, req_out=0, data_out=0;
- synchronizer flops, timeout counter and timeout_err to 0.
REQ-033 in_ready is 0 while rst_n=0 and is 1 from the first edge after release.
REQ-034 Reset in mid-handshake drops req_out at the reset edge and discards the in-flight word and all FIFO contents.
REQ-035 After reset, the FSM reaches REQ_HI only after it has seen ack_s=0 in IDLE; it stays in IDLE while ack_s=1.

Verification
REQ-036 Single word: push 0xA5, with ack_in tied to req_out through a 3-cycle delay -> data_out=0xA5 at t+1, req_out=1 at t+2, one complete 4-phase cycle, busy ends at 0.
REQ-037 Burst: push 0x01..0x06 back-to-back with DEPTH=4 -> in_ready drops at level=4; words are sent in order 0x01..0x06 with none lost or duplicated.
REQ-038 Stall: hold ack_in=0 with TIMEOUT=10 -> timeout_err=1 exactly 10 cycles after REQ_HI entry; req_out stays 1; err_clr clears the flag; releasing ack completes the handshake.
REQ-039 Reset mid-handshake: assert rst_n=0 while in REQ_HI with level=2 -> at the next edge req_out=0, level=0, data_out=0; with ack_in held 1 after release, no new req_out rises.
REQ-040 Data stability: random ack delays of 0-20 cycles over 1000 words -> data_out never changes while req_out=1, and the received sequence equals the sent sequence.
REQ-041 Simultaneous push/pop at level=DEPTH-1 -> level stays DEPTH-1; pushes at level=DEPTH are ignored.
